bitop_result_serializer: RTL and testbench



---
 rtl/bitop_pkg.sv | 24 ++
 rtl/bitop_result_serializer.sv | 121 ++++++++++++
 tb/tb_bitop_result_serializer.sv | 217 +++++++++++++++++++++
 3 files changed

// File: rtl/bitop_pkg.sv
`default_nettype none
// ============================================================================
// Module      : bitop_pkg
// Description : Shared types for the bitwise-operation unit and its result
//               serializer: FSM state encoding and out_sel beat tags.
// Revision    : 1.0 - initial release
// ============================================================================
package bitop_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    S_AND = 3'd1,
    S_OR  = 3'd2,
    S_XOR = 3'd3,
    S_CHK = 3'd4
  } bitop_state_t;

  localparam logic [1:0] SEL_AND = 2'd0;
  localparam logic [1:0] SEL_OR  = 2'd1;
  localparam logic [1:0] SEL_XOR = 2'd2;
  localparam logic [1:0] SEL_CHK = 2'd3;

endpackage
`default_nettype wire

// File: rtl/bitop_result_serializer.sv
`default_nettype none
// ============================================================================
// Module      : bitop_result_serializer
// Description : Takes one (AND, OR, XOR) result triple per handshake and emits
//               it as consecutive tagged beats on a valid/ready channel.
//               Define BITOP_CHECKSUM_EN to append a fourth checksum beat
//               (sum of the three words, modulo 2^WIDTH).
// Revision    : 1.0 - initial release
// ============================================================================
module bitop_result_serializer
  import bitop_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_and,
  input  logic [WIDTH-1:0] in_or,
  input  logic [WIDTH-1:0] in_xor,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [1:0]       out_sel,
  output logic             out_last,
  output logic [CNT_W-1:0] frame_cnt
);

  bitop_state_t     state;
  logic [WIDTH-1:0] hold_or;
  logic [WIDTH-1:0] hold_xor;
  logic             out_hs;
  logic             last_hs;
  logic             in_hs;

`ifdef BITOP_CHECKSUM_EN
  logic [WIDTH-1:0] hold_and;
  logic [WIDTH-1:0] chk_sum;

  // Checksum of the held triple; carries out of the top bit are dropped.
  assign chk_sum = hold_and + hold_or + hold_xor;
`endif

  assign out_hs   = out_valid && out_ready;
  assign last_hs  = out_hs && out_last;
  // Accepting on the final-beat handshake lets frames run back-to-back.
  assign in_ready = (state == IDLE) || last_hs;
  assign in_hs    = in_valid && in_ready;

  // Beat sequencer: captures triples, steps through beats, counts frames.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sel   <= SEL_AND;
      out_last  <= 1'b0;
      frame_cnt <= '0;
      hold_or   <= '0;
      hold_xor  <= '0;
`ifdef BITOP_CHECKSUM_EN
      hold_and  <= '0;
`endif
    end else begin
      // A frame closing on this edge counts whether or not a new one starts.
      if (last_hs) begin
        frame_cnt <= frame_cnt + 1'b1;
      end

      if (in_hs) begin
        // New triple: the AND beat goes straight onto the output registers.
        hold_or   <= in_or;
        hold_xor  <= in_xor;
`ifdef BITOP_CHECKSUM_EN
        hold_and  <= in_and;
`endif
        state     <= S_AND;
        out_valid <= 1'b1;
        out_data  <= in_and;
        out_sel   <= SEL_AND;
        out_last  <= 1'b0;
      end else if (out_hs) begin
        case (state)
          S_AND: begin
            state    <= S_OR;
            out_data <= hold_or;
            out_sel  <= SEL_OR;
          end
          S_OR: begin
            state    <= S_XOR;
            out_data <= hold_xor;
            out_sel  <= SEL_XOR;
`ifdef BITOP_CHECKSUM_EN
            out_last <= 1'b0;
`else
            out_last <= 1'b1;
`endif
          end
`ifdef BITOP_CHECKSUM_EN
          S_XOR: begin
            state    <= S_CHK;
            out_data <= chk_sum;
            out_sel  <= SEL_CHK;
            out_last <= 1'b1;
          end
`endif
          default: begin
            // Final beat accepted with no follow-on triple: go idle.
            state     <= IDLE;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_bitop_result_serializer.sv
`default_nettype none
// ============================================================================
// Module      : tb_bitop_result_serializer
// Description : Self-checking bench for bitop_result_serializer. A queue-based
//               model of expected beats is compared against the DUT every
//               cycle; directed literals pin the model. Honors
//               BITOP_CHECKSUM_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_bitop_result_serializer;
  import bitop_pkg::*;

  localparam int WIDTH = 16;
  localparam int CNT_W = 8;
`ifdef BITOP_CHECKSUM_EN
  localparam int NB = 4;
`else
  localparam int NB = 3;
`endif

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [WIDTH-1:0] in_and = '0;
  logic [WIDTH-1:0] in_or = '0;
  logic [WIDTH-1:0] in_xor = '0;
  logic             out_valid;
  logic             out_ready = 1'b1;
  logic [WIDTH-1:0] out_data;
  logic [1:0]       out_sel;
  logic             out_last;
  logic [CNT_W-1:0] frame_cnt;

  bitop_result_serializer #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_and(in_and), .in_or(in_or), .in_xor(in_xor),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_sel(out_sel), .out_last(out_last),
    .frame_cnt(frame_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [WIDTH-1:0] d;
    logic [1:0]       s;
  } beat_t;

  beat_t mq[$];     // beats the model expects, head is on the bus
  beat_t seen[$];   // beats actually handed over by the DUT
  int    mcnt = 0;
  bit    mvalid = 0;
  int    cyc = 0;
  int    total = 0;
  int    bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Ready when nothing is pending, or the last pending beat is leaving now.
  function automatic bit m_ready();
    return (mq.size() == 0) || (mq.size() == 1 && out_ready);
  endfunction

  // Reference model: frame = list of beats; pop on acceptance, count frames.
  always @(posedge clk) begin
    cyc++;
    if (rst) begin
      mq.delete();
      mcnt = 0;
      mvalid = 1;
    end else begin
      bit rdy;
      rdy = m_ready();
      if (mq.size() > 0 && out_ready) begin
        void'(mq.pop_front());
        if (mq.size() == 0) mcnt = (mcnt + 1) % (1 << CNT_W);
      end
      if (in_valid && rdy) begin
        mq.push_back('{in_and, 2'd0});
        mq.push_back('{in_or,  2'd1});
        mq.push_back('{in_xor, 2'd2});
`ifdef BITOP_CHECKSUM_EN
        mq.push_back('{WIDTH'((int'(in_and) + int'(in_or) + int'(in_xor)) % 65536), 2'd3});
`endif
      end
    end
  end

  // Cycle-by-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (mvalid) begin
      chk("out_valid", {31'd0, out_valid}, {31'd0, mq.size() > 0});
      chk("in_ready", {31'd0, in_ready}, {31'd0, m_ready()});
      chk("frame_cnt", 32'(frame_cnt), 32'(mcnt));
      if (mq.size() > 0) begin
        chk("out_data", 32'(out_data), 32'(mq[0].d));
        chk("out_sel", 32'(out_sel), 32'(mq[0].s));
        chk("out_last", {31'd0, out_last}, {31'd0, mq.size() == 1});
      end
      if (!rst && out_valid && out_ready) seen.push_back('{out_data, out_sel});
    end
  end

  task automatic send(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] o,
                      input logic [WIDTH-1:0] x);
    in_and = a; in_or = o; in_xor = x; in_valid = 1'b1;
    for (int i = 0; i < 100; i++) begin
      if (m_ready()) begin
        @(posedge clk); #1;
        in_valid = 1'b0;
        return;
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    chk("send_timeout", 32'd1, 32'd0);
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  initial begin
    int t0;
    rst = 1'b1;
    idle_cycles(2);
    rst = 1'b0;

    // Idle after reset
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_frame_cnt", 32'(frame_cnt), 32'd0);

    // Frame 1: plain flow
    seen.delete();
    send(16'h0000, 16'h49A2, 16'h49A2);
    idle_cycles(NB + 1);
    chk("f1_n_beats", 32'(seen.size()), 32'(NB));
    if (seen.size() >= NB) begin
      chk("f1_b0_data", 32'(seen[0].d), 32'h0000);
      chk("f1_b0_sel", 32'(seen[0].s), 32'd0);
      chk("f1_b1_data", 32'(seen[1].d), 32'h49A2);
      chk("f1_b1_sel", 32'(seen[1].s), 32'd1);
      chk("f1_b2_data", 32'(seen[2].d), 32'h49A2);
      chk("f1_b2_sel", 32'(seen[2].s), 32'd2);
`ifdef BITOP_CHECKSUM_EN
      chk("f1_chk_data", 32'(seen[3].d), 32'h9344);
      chk("f1_chk_sel", 32'(seen[3].s), 32'd3);
`endif
    end
    chk("f1_frame_cnt", 32'(frame_cnt), 32'd1);

    // Frame 2: stall on the OR beat for five cycles
    seen.delete();
    send(16'h0001, 16'hA541, 16'hA540);
    idle_cycles(1);
    out_ready = 1'b0;
    repeat (5) begin
      @(negedge clk);
      chk("stall_or_data", 32'(out_data), 32'hA541);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    idle_cycles(NB + 1);
    chk("f2_n_beats", 32'(seen.size()), 32'(NB));
`ifdef BITOP_CHECKSUM_EN
    if (seen.size() >= 4) chk("f2_chk_data", 32'(seen[3].d), 32'h4A82);
`endif
    chk("f2_frame_cnt", 32'(frame_cnt), 32'd2);

    // Back-to-back frames with in_valid held high
    send(16'h1234, 16'h5678, 16'h9ABC);
    t0 = cyc;
    send(16'hFFFF, 16'h0F0F, 16'hF0F0);
    chk("b2b_gap", 32'(cyc - t0), 32'(NB));
    idle_cycles(NB + 1);
    chk("b2b_frame_cnt", 32'(frame_cnt), 32'd4);

    // Reset during the OR beat
    send(16'hAAAA, 16'h5555, 16'hFFFF);
    idle_cycles(1);
    rst = 1'b1;
    idle_cycles(1);
    rst = 1'b0;
    chk("midrst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("midrst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("midrst_frame_cnt", 32'(frame_cnt), 32'd0);

    // Counter wrap: 255 frames then one more
    for (int i = 0; i < 255; i++) send(16'(i), 16'(i * 3), 16'(i ^ 16'h00FF));
    idle_cycles(NB + 1);
    chk("wrap_255", 32'(frame_cnt), 32'd255);
    send(16'hBEEF, 16'hCAFE, 16'h1111);
    idle_cycles(NB + 1);
    chk("wrap_0", 32'(frame_cnt), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Absolute time limit so the run always ends.
  initial begin
    #2000000;
    $display("FAIL global_timeout: got=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
